// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The master side is the controller; the slave side is the datapath/IR.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       InstrDone;
  logic [3:0] State;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone, State
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RISC-V core: steps the shared ALU, memory
// port and register file through fetch/decode/execute/memory/writeback phases.
module multicycle_controller (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_e     state_q, state_d;
  state_e     dec_state;
  aluop_e     alu_op;
  logic       legal;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_ctl;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // While reset is held the datapath sees the FETCH decode with enables gated off.
  assign dec_state = reset ? state_q : S_FETCH;

  always_comb begin
    state_d    = S_FETCH;
    alu_op     = ALUOP_ADD;
    legal      = 1'b1;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    unique case (dec_state)
      S_FETCH: begin
        state_d    = S_DECODE;
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        unique case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
          default: begin
            state_d    = S_FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        state_d   = S_ALUWB;
        alu_src_a = 2'b10;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        state_d   = S_ALUWB;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        state_d   = S_ALUWB;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = ALUOP_SUB;
        pc_write   = bus.Zero;
        instr_done = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctl = 3'b000;
    unique case (alu_op)
      ALUOP_SUB: alu_ctl = 3'b001;
      ALUOP_FUNCT: begin
        unique case (bus.funct3)
          3'b000:  alu_ctl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctl = 3'b101;
          3'b110:  alu_ctl = 3'b011;
          3'b111:  alu_ctl = 3'b010;
          default: alu_ctl = 3'b000;
        endcase
      end
      default: alu_ctl = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    unique case (bus.op)
      OP_STORE: imm_src = 2'b01;
      OP_BEQ:   imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  assign bus.PCWrite    = pc_write & reset;
  assign bus.MemWrite   = mem_write & reset;
  assign bus.IRWrite    = ir_write & reset;
  assign bus.RegWrite   = reg_write & reset;
  assign bus.InstrDone  = instr_done & reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = legal ? imm_src : 2'b00;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction table plus hand-written
// reset and per-phase output sequences.
module tb_multicycle_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        zero;
    int          n;
    logic [23:0] seq;
    logic [3:0]  alu_st;
    logic [2:0]  alu_exp;
    logic [1:0]  imm;
    logic        pcw_last;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic zero);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.Zero     = zero;
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] st;
    set_in(v.op, v.f3, v.f7, v.zero);
    for (int k = 0; k < v.n; k++) begin
      st = v.seq[4*k +: 4];
      chk({v.name, ".state"}, 32'(bus.State), 32'(st));
      chk({v.name, ".done"}, 32'(bus.InstrDone), 32'(k == v.n - 1));
      chk({v.name, ".imm"}, 32'(bus.ImmSrc), 32'(v.imm));
      if (st == v.alu_st) chk({v.name, ".aluctl"}, 32'(bus.ALUControl), 32'(v.alu_exp));
      if (k == v.n - 1) chk({v.name, ".pcw_last"}, 32'(bus.PCWrite), 32'(v.pcw_last));
      @(negedge clk);
    end
    chk({v.name, ".back_to_fetch"}, 32'(bus.State), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;

    vecs[0]  = '{"lw",     7'b0000011, 3'b010, 1'b0, 1'b1, 5, 24'h043210, 4'd2,  3'b000, 2'b00, 1'b0};
    vecs[1]  = '{"sw",     7'b0100011, 3'b010, 1'b0, 1'b1, 4, 24'h005210, 4'd2,  3'b000, 2'b01, 1'b0};
    vecs[2]  = '{"sub",    7'b0110011, 3'b000, 1'b1, 1'b1, 4, 24'h007610, 4'd6,  3'b001, 2'b00, 1'b0};
    vecs[3]  = '{"add",    7'b0110011, 3'b000, 1'b0, 1'b1, 4, 24'h007610, 4'd6,  3'b000, 2'b00, 1'b0};
    vecs[4]  = '{"addi",   7'b0010011, 3'b000, 1'b1, 1'b1, 4, 24'h007810, 4'd8,  3'b000, 2'b00, 1'b0};
    vecs[5]  = '{"slt",    7'b0110011, 3'b010, 1'b0, 1'b0, 4, 24'h007610, 4'd6,  3'b101, 2'b00, 1'b0};
    vecs[6]  = '{"or",     7'b0110011, 3'b110, 1'b0, 1'b0, 4, 24'h007610, 4'd6,  3'b011, 2'b00, 1'b0};
    vecs[7]  = '{"andi",   7'b0010011, 3'b111, 1'b0, 1'b0, 4, 24'h007810, 4'd8,  3'b010, 2'b00, 1'b0};
    vecs[8]  = '{"slli",   7'b0010011, 3'b001, 1'b0, 1'b0, 4, 24'h007810, 4'd8,  3'b000, 2'b00, 1'b0};
    vecs[9]  = '{"beq_t",  7'b1100011, 3'b000, 1'b0, 1'b1, 3, 24'h000A10, 4'd10, 3'b001, 2'b10, 1'b1};
    vecs[10] = '{"beq_nt", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, 24'h000A10, 4'd10, 3'b001, 2'b10, 1'b0};
    vecs[11] = '{"jal",    7'b1101111, 3'b000, 1'b0, 1'b1, 4, 24'h007910, 4'd9,  3'b000, 2'b11, 1'b1};
    vecs[12] = '{"nop",    7'b0000000, 3'b000, 1'b0, 1'b1, 2, 24'h000010, 4'd1,  3'b000, 2'b00, 1'b0};
    // jal's final cycle is ALUWB, where PCWrite must be low.
    vecs[11].pcw_last = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.state", 32'(bus.State), 32'd0);
    chk("rst.irwrite_gated", 32'(bus.IRWrite), 32'd0);
    reset = 1'b1;
    #1;
    chk("first_fetch.irwrite", 32'(bus.IRWrite), 32'd1);
    chk("first_fetch.pcwrite", 32'(bus.PCWrite), 32'd1);

    // Reset held mid-instruction while in EXECR.
    set_in(7'b0110011, 3'b000, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst.in_execr", 32'(bus.State), 32'd6);
    reset = 1'b0;
    #1;
    chk("midrst.fetch_decode_srcb", 32'(bus.ALUSrcB), 32'd2);
    chk("midrst.irwrite0", 32'(bus.IRWrite), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst.state", 32'(bus.State), 32'd0);
      chk("midrst.enables", {27'd0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite,
                             bus.InstrDone}, 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("release.irwrite", 32'(bus.IRWrite), 32'd1);
    chk("release.pcwrite", 32'(bus.PCWrite), 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // lw phase-by-phase datapath controls.
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    chk("lw.f.adrsrc", 32'(bus.AdrSrc), 32'd0);
    chk("lw.f.srcb", 32'(bus.ALUSrcB), 32'd2);
    chk("lw.f.resultsrc", 32'(bus.ResultSrc), 32'd2);
    chk("lw.f.srca", 32'(bus.ALUSrcA), 32'd0);
    @(negedge clk);
    chk("lw.d.srca", 32'(bus.ALUSrcA), 32'd1);
    chk("lw.d.srcb", 32'(bus.ALUSrcB), 32'd1);
    chk("lw.d.pcwrite", 32'(bus.PCWrite), 32'd0);
    @(negedge clk);
    chk("lw.ma.srca", 32'(bus.ALUSrcA), 32'd2);
    chk("lw.ma.srcb", 32'(bus.ALUSrcB), 32'd1);
    @(negedge clk);
    chk("lw.mr.adrsrc", 32'(bus.AdrSrc), 32'd1);
    chk("lw.mr.regwrite", 32'(bus.RegWrite), 32'd0);
    chk("lw.mr.resultsrc", 32'(bus.ResultSrc), 32'd0);
    @(negedge clk);
    chk("lw.wb.regwrite", 32'(bus.RegWrite), 32'd1);
    chk("lw.wb.resultsrc", 32'(bus.ResultSrc), 32'd1);
    chk("lw.wb.adrsrc", 32'(bus.AdrSrc), 32'd0);
    @(negedge clk);
    chk("lw.end.state", 32'(bus.State), 32'd0);

    // sw: MemWrite only in MEMWRITE.
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    chk("sw.f.memwrite", 32'(bus.MemWrite), 32'd0);
    @(negedge clk);
    chk("sw.d.memwrite", 32'(bus.MemWrite), 32'd0);
    @(negedge clk);
    chk("sw.ma.memwrite", 32'(bus.MemWrite), 32'd0);
    @(negedge clk);
    chk("sw.mw.memwrite", 32'(bus.MemWrite), 32'd1);
    chk("sw.mw.adrsrc", 32'(bus.AdrSrc), 32'd1);
    chk("sw.mw.regwrite", 32'(bus.RegWrite), 32'd0);
    @(negedge clk);
    chk("sw.end.memwrite", 32'(bus.MemWrite), 32'd0);

    // jal: target load and link computation.
    set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("jal.j.pcwrite", 32'(bus.PCWrite), 32'd1);
    chk("jal.j.srca", 32'(bus.ALUSrcA), 32'd1);
    chk("jal.j.srcb", 32'(bus.ALUSrcB), 32'd2);
    chk("jal.j.resultsrc", 32'(bus.ResultSrc), 32'd0);
    @(negedge clk);
    chk("jal.wb.regwrite", 32'(bus.RegWrite), 32'd1);
    chk("jal.wb.pcwrite", 32'(bus.PCWrite), 32'd0);
    @(negedge clk);
    chk("jal.end.state", 32'(bus.State), 32'd0);

    // beq datapath selects with Zero deasserted.
    set_in(7'b1100011, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("beq.srca", 32'(bus.ALUSrcA), 32'd2);
    chk("beq.srcb", 32'(bus.ALUSrcB), 32'd0);
    bus.Zero = 1'b1;
    #1;
    chk("beq.zero_comb", 32'(bus.PCWrite), 32'd1);
    @(negedge clk);
    chk("beq.end.state", 32'(bus.State), 32'd0);

    // Reset from MEMWRITE abandons the store.
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("swrst.in_memwrite", 32'(bus.State), 32'd5);
    reset = 1'b0;
    #1;
    chk("swrst.memwrite_gated", 32'(bus.MemWrite), 32'd0);
    @(negedge clk);
    chk("swrst.state", 32'(bus.State), 32'd0);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
